mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative unsigned multiply/divide unit for the EX stage of the pipelined datapath.
- Consumes operands held in the ID/EX pipeline register and produces a 2W-bit result (hi/lo) that the EX/MEM register and the register-file write-back path consume.
- Handshake is start/busy/done. The hazard logic stalls the pipeline while busy=1.

Parameters:
- WORD_LENGTH, 16, operand width W; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on posedge only while not busy.
- op  input  1  operation: 0 = MULU, 1 = DIVU.
- a  input  W  multiplicand / dividend.
- b  input  W  multiplier / divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- hi  output  W  MULU: upper product half; DIVU: remainder.
- lo  output  W  MULU: lower product half; DIVU: quotient.
- div_by_zero  output  1  last completed op was DIVU with b==0.

Behaviour:
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; iteration counter 0. Reset takes priority over every other event, including mid-operation. An in-flight operation is discarded and produces no done pulse.
- States:
  - IDLE: start=1 at edge E0 latches a, b and op internally, loads the counter with W, and moves to RUN.
  - RUN: one iteration per edge. The counter decrements. On the edge where the counter reaches 0 (edge E_W), final hi/lo/div_by_zero are loaded and the state moves to DONE.
  - DONE: lasts one cycle. start=1 here is accepted exactly as in IDLE (back-to-back). Otherwise the state returns to IDLE.
- busy=1 exactly in RUN. done=1 exactly in DONE. Latency: start sampled at E0 gives done high in the cycle after E_W, i.e. W cycles after acceptance.
- start while busy=1 is ignored; the operand inputs may change freely during RUN.
- MULU: shift-add, one multiplier bit per iteration. Result {hi,lo} = a*b, full 2W bits, no truncation.
- DIVU: restoring division, one quotient bit per iteration, MSB first.
  - Partial remainder is W+1 bits wide.
  - Result: lo = a / b, hi = a % b.
- b==0 under DIVU: no special path, normal latency. The algorithm yields lo = all ones and hi = a, and div_by_zero=1.
- div_by_zero is cleared on any completed MULU and on any DIVU with b!=0.
- hi, lo and div_by_zero are updated only at completion (edge E_W). They hold their previous values during RUN and IDLE until the next completion.
- op is reserved to 1 bit; no other encodings exist.

Decomposition:
- Package mult_div_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}
  - constants OP_MULU=1'b0 and OP_DIVU=1'b1
- Result holding uses the existing register module: parameter WORD_LENGTH=2W+1, ld = completion strobe, rst = rst, holding {div_by_zero, hi, lo}. The datapath and FSM stay in mult_div_unit.

Test Plan:
- Reset, then MULU a=300, b=200 → busy high for 16 cycles, done pulse, hi=16'h0000, lo=16'hEA60, div_by_zero=0.
- MULU a=16'hFFFF, b=16'hFFFF → hi=16'hFFFE, lo=16'h0001. Then DIVU a=1000, b=7 → lo=142, hi=6.
- DIVU a=16'h1234, b=0 → lo=16'hFFFF, hi=16'h1234, div_by_zero=1. A following MULU 3*5 → lo=15, hi=0, div_by_zero=0.
- start pulsed with new operands during RUN (cycle 5) → ignored. The original result appears at the original cycle and only one done pulse occurs.
- rst asserted asynchronously at RUN cycle 8 → busy=0, done=0, hi=lo=0 immediately, no done pulse. Then DIVU 100/9 → lo=11, hi=1.
- start held high in the DONE cycle with MULU 2*3 after DIVU 50/5 → first done shows lo=10, hi=0. The second op is accepted with no idle gap and gives a second done exactly 16 cycles later with lo=6.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and opcodes for the iterative multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

endpackage

// File: rtl/register.sv
// Generic load-enabled holding register with asynchronous clear.
module register #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld,
    input  logic [WORD_LENGTH-1:0] d,
    output logic [WORD_LENGTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The FSM and shared datapath live here; results are held in a register instance.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [WORD_LENGTH-1:0] a,
    input  logic [WORD_LENGTH-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] hi,
    output logic [WORD_LENGTH-1:0] lo,
    output logic                   div_by_zero
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic           op_reg;
    logic [W-1:0]   opnd_reg;   // multiplicand (MULU) or divisor (DIVU)
    logic [W:0]     part_reg, part_next;
    logic [W-1:0]   quo_reg, quo_next;

    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W+1:0]   diff;
    logic           last;
    logic [2*W:0]   result_d;
    logic [2*W:0]   result_q;

    // MULU: part holds the running upper half, quo shifts the multiplier out.
    // DIVU: part is the partial remainder, quo shifts dividend out / quotient in.
    always_comb begin
        sum       = quo_reg[0] ? (part_reg + {1'b0, opnd_reg}) : part_reg;
        shifted   = {part_reg[W-1:0], quo_reg[W-1]};
        diff      = {1'b0, shifted} - {2'b00, opnd_reg};
        part_next = part_reg;
        quo_next  = quo_reg;
        if (op_reg == OP_MULU) begin
            {part_next, quo_next} = {sum, quo_reg} >> 1;
        end else if (!diff[W+1]) begin
            part_next = diff[W:0];
            quo_next  = {quo_reg[W-2:0], 1'b1};
        end else begin
            part_next = shifted;
            quo_next  = {quo_reg[W-2:0], 1'b0};
        end
    end

    assign last     = (state_reg == RUN) && (cnt_reg == CW'(1));
    assign result_d = {(op_reg == OP_DIVU) && (opnd_reg == '0), part_next[W-1:0], quo_next};

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_MULU;
            opnd_reg  <= '0;
            part_reg  <= '0;
            quo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RUN) begin
                cnt_reg  <= cnt_reg - CW'(1);
                part_reg <= part_next;
                quo_reg  <= quo_next;
            end else if (start) begin
                op_reg   <= op;
                cnt_reg  <= CW'(W);
                part_reg <= '0;
                opnd_reg <= (op == OP_DIVU) ? b : a;
                quo_reg  <= (op == OP_DIVU) ? a : b;
            end
        end
    end

    register #(
        .WORD_LENGTH(2 * W + 1)
    ) u_result (
        .clk (clk),
        .rst (rst),
        .ld  (last),
        .d   (result_d),
        .q   (result_q)
    );

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign div_by_zero = result_q[2*W];
    assign hi          = result_q[2*W-1:W];
    assign lo          = result_q[W-1:0];

endmodule
